// File: rtl/sort_pkg.sv
// Shared types for the sort_32_u8 frame sorter and its unload stage.
// Frame layout: byte i of a frame lives at flat bits [8i+7:8i].
package sort_pkg;

  localparam int SORT_N    = 32;
  localparam int SORT_W    = 8;
  localparam int SORT_IDXW = 5;

  typedef logic [SORT_W-1:0] sort_byte_t;
  typedef sort_byte_t [SORT_N-1:0] sort_frame_t;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_ONE,
    Q_FULL
  } q_state_t;

  function automatic sort_frame_t sort_unpack(
    input logic [SORT_N*SORT_W-1:0] flat
  );
    sort_frame_t f;
    for (int i = 0; i < SORT_N; i++)
      f[i] = flat[i*SORT_W +: SORT_W];
    return f;
  endfunction

endpackage

// File: rtl/sort_32_u8_unload_if.sv
// Byte stream out of the unload stage.
// Valid/ready handshake; idx and last tag the position in the frame.
interface sort_32_u8_unload_if;
  import sort_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  sort_byte_t           out_data;
  logic [SORT_IDXW-1:0] out_idx;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sort_frame_buf.sv
// One frame store: loads a whole frame, reads back one byte.
// Contents need no reset; a frame is only read after it is loaded.
module sort_frame_buf
  import sort_pkg::*;
(
  input  logic                 clk,
  input  logic                 ld,
  input  sort_frame_t          d,
  input  logic [SORT_IDXW-1:0] sel,
  output sort_byte_t           q
);

  sort_frame_t mem;

  // capture a full frame on load
  always_ff @(posedge clk) begin
    if (ld) mem <= d;
  end

  assign q = mem[sel];

endmodule

// File: rtl/sort_32_u8_unload.sv
// Ping-pong capture of sorted frames, streamed out a byte per beat.
// Frames arriving with both buffers busy are dropped and counted.
module sort_32_u8_unload
  import sort_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_in,
  input  logic [SORT_N*SORT_W-1:0] din,
  input  logic                     ovf_clr,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  sort_32_u8_unload_if.master      out_if
);

  localparam logic [SORT_IDXW-1:0] LAST =
    SORT_IDXW'(SORT_N - 1);

  q_state_t             state_q, state_d;
  logic                 wp, rp;
  logic [SORT_IDXW-1:0] idx_q;
  logic                 beat, frame_done;
  logic                 accept, drop;
  logic                 valid;
  sort_frame_t          frame;
  sort_byte_t           q0, q1;

  assign frame = sort_unpack(din);
  assign valid = (state_q != Q_EMPTY);

  sort_frame_buf u_buf0 (
    .clk (clk),
    .ld  (accept && !wp),
    .d   (frame),
    .sel (idx_q),
    .q   (q0)
  );

  sort_frame_buf u_buf1 (
    .clk (clk),
    .ld  (accept && wp),
    .d   (frame),
    .sel (idx_q),
    .q   (q1)
  );

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= Q_EMPTY;
    else        state_q <= state_d;
  end

  // accept/drop decision and occupancy next-state
  always_comb begin
    state_d    = state_q;
    beat       = valid && out_if.out_ready;
    frame_done = beat && (idx_q == LAST);
    accept     = vld_in &&
                 ((state_q != Q_FULL) || frame_done);
    drop       = vld_in && !accept;
    case (state_q)
      Q_EMPTY: begin
        if (accept) state_d = Q_ONE;
      end
      Q_ONE: begin
        if (accept && !frame_done)
          state_d = Q_FULL;
        else if (!accept && frame_done)
          state_d = Q_EMPTY;
      end
      Q_FULL: begin
        if (frame_done && !accept)
          state_d = Q_ONE;
      end
      default: state_d = Q_EMPTY;
    endcase
  end

  // buffer pointers and byte index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      idx_q <= '0;
    end else begin
      if (accept) wp <= ~wp;
      if (frame_done) begin
        rp    <= ~rp;
        idx_q <= '0;
      end else if (beat) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // overflow flag and saturating drop counter; drop beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign out_if.out_valid = valid;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = valid && (idx_q == LAST);
  assign out_if.out_data  = !valid ? '0 :
                            (rp ? q1 : q0);

endmodule

// File: tb/tb_sort_32_u8_unload.sv
// Randomised and directed bench for sort_32_u8_unload.
// Reference: queue of pending frames plus read position.
module tb_sort_32_u8_unload;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld_in;
  logic [255:0] din;
  logic         ovf_clr;
  logic         ovf;
  logic [7:0]   drop_cnt;

  sort_32_u8_unload_if sif ();

  sort_32_u8_unload dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_in),
    .din      (din),
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .out_if   (sif)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [255:0] mq[$];
  int           pos = 0;
  bit           movf = 0;
  int           mdc = 0;
  int           nbeat = 0;
  int           nlast = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [255:0] f,
                      input logic r,
                      input logic c);
    logic beat, done, acc;
    @(negedge clk);
    vld_in        = v;
    din           = f;
    sif.out_ready = r;
    ovf_clr       = c;
    #1;
    chk("valid", 32'(sif.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("data", 32'(sif.out_data), 32'(mq[0][pos*8 +: 8]));
      chk("idx", 32'(sif.out_idx), 32'(pos));
      chk("last", 32'(sif.out_last), 32'(pos == 31));
    end else begin
      chk("data_idle", 32'(sif.out_data), 32'd0);
      chk("last_idle", 32'(sif.out_last), 32'd0);
    end
    chk("ovf", 32'(ovf), 32'(movf));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdc));
    beat = (mq.size() != 0) && r;
    done = beat && (pos == 31);
    acc  = v && ((mq.size() < 2) || done);
    if (beat) nbeat++;
    if (beat && sif.out_last) nlast++;
    @(posedge clk);
    if (done) begin
      void'(mq.pop_front());
      pos = 0;
    end else if (beat) begin
      pos++;
    end
    if (acc) mq.push_back(f);
    if (v && !acc) begin
      movf = 1;
      mdc  = c ? 1 : (mdc == 255 ? 255 : mdc + 1);
    end else if (c) begin
      movf = 0;
      mdc  = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (mq.size() != 0 && n < budget) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  function automatic logic [255:0] rnd_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] f;
    for (int i = 0; i < 32; i++) f[i*8 +: 8] = 8'(i);
    return f;
  endfunction

  initial begin
    int v[32];
    int tl[16];
    int t;
    logic [255:0] fs, fa, fb, fc;
    tl = '{2,2,4,4,4,4,8,16,8,16,32,32,0,10,20,30};
    rst_n = 1'b0; vld_in = 1'b0; din = '0;
    ovf_clr = 1'b0; sif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_data", 32'(sif.out_data), 32'd0);
    chk("rst_idx", 32'(sif.out_idx), 32'd0);
    chk("rst_last", 32'(sif.out_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_dc", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sorted frame, ready held high
    for (int i = 0; i < 16; i++) v[i] = 31 - 2*i;
    for (int i = 0; i < 16; i++) v[16+i] = tl[i];
    for (int i = 1; i < 32; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    for (int i = 0; i < 32; i++) fs[i*8 +: 8] = 8'(v[i]);
    chk("sort_first", 32'(fs[7:0]), 32'd0);
    nbeat = 0; nlast = 0;
    step(1'b1, fs, 1'b1, 1'b0);
    drain(100);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_beats", 32'(nbeat), 32'd32);
    chk("t1_lasts", 32'(nlast), 32'd1);

    // 2: stalls with ready 1,0,0 pattern
    nbeat = 0;
    step(1'b1, fs, 1'b1, 1'b0);
    for (int n = 0; n < 200 && mq.size() != 0; n++)
      step(1'b0, '0, 1'((n % 3) == 0), 1'b0);
    chk("t2_beats", 32'(nbeat), 32'd32);
    chk("t2_empty", 32'(mq.size()), 32'd0);

    // 3: two frames back to back
    fa = ramp();
    fb = {32{8'hAA}};
    nbeat = 0; nlast = 0;
    step(1'b1, fa, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, fb, 1'b1, 1'b0);
    drain(200);
    chk("t3_beats", 32'(nbeat), 32'd64);
    chk("t3_lasts", 32'(nlast), 32'd2);

    // 4: third frame dropped while stalled, then clear
    fc = rnd_frame();
    step(1'b1, fa, 1'b0, 1'b0);
    step(1'b1, fb, 1'b0, 1'b0);
    step(1'b1, fc, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_dc", 32'(drop_cnt), 32'd1);
    drain(200);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // 5: accept on the completing beat while full
    step(1'b1, fa, 1'b0, 1'b0);
    step(1'b1, fb, 1'b0, 1'b0);
    repeat (31) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, fc, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t5_ovf", 32'(ovf), 32'd0);
    chk("t5_depth", 32'(mq.size()), 32'd2);
    drain(200);
    // clear together with a drop
    step(1'b1, fa, 1'b0, 1'b0);
    step(1'b1, fb, 1'b0, 1'b0);
    step(1'b1, fc, 1'b0, 1'b0);
    step(1'b1, fc, 1'b0, 1'b0);
    step(1'b1, fc, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t5_clrdrop_dc", 32'(drop_cnt), 32'd1);
    // saturation of the drop counter
    repeat (258) step(1'b1, fc, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sat_dc", 32'(drop_cnt), 32'd255);
    drain(200);
    step(1'b0, '0, 1'b0, 1'b1);

    // 6: async reset mid-frame
    step(1'b1, fa, 1'b1, 1'b0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(sif.out_valid), 32'd0);
    chk("t6_idx", 32'(sif.out_idx), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    mq.delete();
    pos = 0; movf = 0; mdc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, fb, 1'b1, 1'b0);
    drain(100);

    // random traffic
    for (int n = 0; n < 2000; n++)
      step(1'(($urandom % 6) == 0), rnd_frame(),
           1'($urandom % 2), 1'(($urandom % 40) == 0));
    drain(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
